hilo_muldiv: RTL

Multi-cycle unsigned multiply/divide unit that owns the HI/LO register pair in the EX stage. It consumes the `ALU_CONTROL_*` codes emitted by `alu_control` for the HI/LO group (MULTU, DIVU, MTHI, MTLO, MFHI, MFLO) and executes them with a 32-step iterative datapath. It returns MFHI/MFLO read data and drives a stall request to the pipeline control while an operation is in flight. All other control codes are ignored.

---
 rtl/hilo_muldiv.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/hilo_muldiv.sv
// hilo_muldiv
// Multi-cycle unsigned multiply/divide unit that owns the HI/LO register
// pair in the EX stage. MULTU and DIVU run a WIDTH-step iterative datapath
// (shift-add multiply, restoring divide). MTHI/MTLO write HI/LO in one
// cycle. MFHI/MFLO return HI/LO combinationally. While an operation is in
// flight, any further HI/LO instruction is held in EX by a stall request.
// All other control codes are ignored.
//
// Ports:
//   clk          rising-edge clock
//   rst          synchronous reset, active-high
//   valid        EX-stage instruction is live (not a bubble)
//   alu_control  decoded operation code; the encodings below must match head.v
//   a            rs value: dividend, multiplicand, or MTHI/MTLO source
//   b            rt value: divisor or multiplier
//   stall        combinational stall request (hold IF/ID/EX, bubble MEM)
//   rdata        combinational MFHI/MFLO read data, 0 for other codes
//   hi, lo       HI/LO registers, for debug and trace
//   done         one-cycle pulse in the cycle after MULTU/DIVU wrote HI/LO
module hilo_muldiv #(
  parameter int WIDTH              = 32,
  parameter int ALU_CONTROL_LENGTH = 5,
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MULTU = ALU_CONTROL_LENGTH'(16),
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_DIVU  = ALU_CONTROL_LENGTH'(17),
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTHI  = ALU_CONTROL_LENGTH'(18),
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MTLO  = ALU_CONTROL_LENGTH'(19),
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFHI  = ALU_CONTROL_LENGTH'(20),
  parameter logic [ALU_CONTROL_LENGTH-1:0] ALU_CONTROL_MFLO  = ALU_CONTROL_LENGTH'(21)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          valid,
  input  logic [ALU_CONTROL_LENGTH-1:0] alu_control,
  input  logic [WIDTH-1:0]              a,
  input  logic [WIDTH-1:0]              b,
  output logic                          stall,
  output logic [WIDTH-1:0]              rdata,
  output logic [WIDTH-1:0]              hi,
  output logic [WIDTH-1:0]              lo,
  output logic                          done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV
  } state_t;

  state_t             state;
  state_t             next_state;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               done_q;

  logic is_multu, is_divu, is_mthi, is_mtlo, is_mfhi, is_mflo;
  logic go;
  logic last_step;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_up;
  logic               div_ge;
  logic [WIDTH-1:0]   div_diff;
  logic [2*WIDTH-1:0] div_next;

  // Operation decode; only live HI/LO-group instructions engage the unit.
  always_comb begin
    is_multu  = (alu_control == ALU_CONTROL_MULTU);
    is_divu   = (alu_control == ALU_CONTROL_DIVU);
    is_mthi   = (alu_control == ALU_CONTROL_MTHI);
    is_mtlo   = (alu_control == ALU_CONTROL_MTLO);
    is_mfhi   = (alu_control == ALU_CONTROL_MFHI);
    is_mflo   = (alu_control == ALU_CONTROL_MFLO);
    go        = valid & (is_multu | is_divu | is_mthi | is_mtlo | is_mfhi | is_mflo);
    last_step = (cnt == LAST_CNT);
  end

  // One iteration of each algorithm. The divide comparison keeps the bit
  // shifted out of the upper half so divisors above 2^(WIDTH-1) still work;
  // the difference always fits back into WIDTH bits.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
    mul_next = {mul_sum, acc[WIDTH-1:1]};

    div_up   = acc[2*WIDTH-1:WIDTH-1];
    div_ge   = (div_up >= {1'b0, opnd});
    div_diff = div_up[WIDTH-1:0] - opnd;
    div_next = div_ge ? {div_diff, acc[WIDTH-2:0], 1'b1}
                      : {acc[2*WIDTH-2:0], 1'b0};
  end

  // FSM next state and stall. A HI/LO instruction arriving while busy is
  // held by stall; anything else flows through untouched.
  always_comb begin
    next_state = state;
    stall      = 1'b0;
    case (state)
      S_IDLE: begin
        if (go && is_multu)     next_state = S_MUL;
        else if (go && is_divu) next_state = S_DIV;
      end
      S_MUL, S_DIV: begin
        stall = go;
        if (last_step) next_state = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Datapath: operand capture on acceptance, one step per busy cycle, and
  // the HI/LO write plus done pulse on the final step. Reset mid-operation
  // simply discards the partial result.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            if (is_multu) begin
              acc  <= {{WIDTH{1'b0}}, b};
              opnd <= a;
              cnt  <= '0;
            end else if (is_divu) begin
              acc  <= {{WIDTH{1'b0}}, a};
              opnd <= b;
              cnt  <= '0;
            end else if (is_mthi) begin
              hi_q <= a;
            end else if (is_mtlo) begin
              lo_q <= a;
            end
          end
        end
        S_MUL, S_DIV: begin
          acc <= (state == S_MUL) ? mul_next : div_next;
          cnt <= cnt + CNT_W'(1);
          if (last_step) begin
            hi_q   <= (state == S_MUL) ? mul_next[2*WIDTH-1:WIDTH] : div_next[2*WIDTH-1:WIDTH];
            lo_q   <= (state == S_MUL) ? mul_next[WIDTH-1:0]       : div_next[WIDTH-1:0];
            cnt    <= '0;
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Read port; not gated by valid since the pipeline discards stalled reads.
  always_comb begin
    rdata = '0;
    if (is_mfhi)      rdata = hi_q;
    else if (is_mflo) rdata = lo_q;
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign done = done_q;

endmodule
